frmpool_arbiter: RTL

- Shares one single-port frame-pool SRAM wrapper between one writer (frame producer) and NUM_RD readers (PE-array fetch ports).
- Performs at most one access per cycle.
- Writes take priority, with a starvation guard. Readers are served round-robin.
- Read data is returned with a requester tag, one cycle after grant, matching the wrapper's 1-cycle read latency.

---
 rtl/frmpool_pkg.sv | 11 +
 rtl/frmpool_arbiter_if.sv | 39 +++
 rtl/frmpool_rr_pick.sv | 32 +++
 rtl/frmpool_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/frmpool_pkg.sv
// Shared constants and grant encoding for the frame-pool arbiter.
package frmpool_pkg;
  localparam int FRMPOOL_DEPTH_BIT = 6;
  localparam int FRMPOOL_WIDTH     = 28;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } gnt_e;
endpackage

// File: rtl/frmpool_arbiter_if.sv
// Requester + SRAM-wrapper bus of the frame-pool arbiter.
// master = requesters/wrapper side, slave = arbiter side.
interface frmpool_arbiter_if
  import frmpool_pkg::*;
#(
  parameter int AW     = FRMPOOL_DEPTH_BIT,
  parameter int DW     = FRMPOOL_WIDTH,
  parameter int NUM_RD = 2,
  parameter int ID_W   = 3
);
  logic                 wr_req;
  logic [AW-1:0]        wr_addr;
  logic [DW-1:0]        wr_data;
  logic                 wr_ack;
  logic [NUM_RD-1:0]    rd_req;
  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD-1:0]    rd_gnt;
  logic                 rd_vld;
  logic [ID_W-1:0]      rd_id;
  logic [DW-1:0]        rd_data;
  logic [AW-1:0]        ram_addr_r;
  logic [AW-1:0]        ram_addr_w;
  logic                 ram_read_en;
  logic                 ram_write_en;
  logic [DW-1:0]        ram_data_in;
  logic [DW-1:0]        ram_data_out;

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_data_out,
    input  wr_ack, rd_gnt, rd_vld, rd_id, rd_data,
           ram_addr_r, ram_addr_w, ram_read_en, ram_write_en, ram_data_in
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_data_out,
    output wr_ack, rd_gnt, rd_vld, rd_id, rd_data,
           ram_addr_r, ram_addr_w, ram_read_en, ram_write_en, ram_data_in
  );
endinterface

// File: rtl/frmpool_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, cyclically.
module frmpool_rr_pick #(
  parameter int N    = 2,
  parameter int ID_W = 3
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] idx,
  output logic            any
);
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    // Pass 1 covers [ptr, N-1], pass 2 wraps to [0, ptr-1].
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (i >= int'(ptr))) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        idx    = ID_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (i < int'(ptr))) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        idx    = ID_W'(i);
      end
    end
  end
endmodule

// File: rtl/frmpool_arbiter.sv
// Single-port frame-pool arbiter: one writer (priority, starvation-guarded) vs
// NUM_RD round-robin readers. Optional stats counter under FRMPOOL_ARB_STAT_EN.
module frmpool_arbiter
  import frmpool_pkg::*;
#(
  parameter int SRAM_DEPTH_BIT = FRMPOOL_DEPTH_BIT,
  parameter int SRAM_WIDTH     = FRMPOOL_WIDTH,
  parameter int NUM_RD         = 2,
  parameter int RD_ID_W        = 3,
  parameter int WR_STARVE_MAX  = 4
) (
  input  logic clk,
  input  logic rst_n,
  frmpool_arbiter_if.slave bus
`ifdef FRMPOOL_ARB_STAT_EN
  ,
  input  logic        stat_clr,
  output logic [15:0] stat_conflict_cnt
`endif
);
  localparam logic [3:0] STARVE_MAX = 4'(WR_STARVE_MAX);

  logic [NUM_RD-1:0][SRAM_DEPTH_BIT-1:0] rd_addr_a;
  logic [NUM_RD-1:0]  pick_gnt;
  logic [RD_ID_W-1:0] pick_idx;
  logic               any_rd;
  gnt_e               gnt_type;

  logic [3:0]         starve_cnt_q, starve_cnt_d;
  logic [RD_ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic               rd_vld_q, rd_vld_d;
  logic [RD_ID_W-1:0] rd_id_q, rd_id_d;

  assign rd_addr_a = bus.rd_addr;

  frmpool_rr_pick #(.N(NUM_RD), .ID_W(RD_ID_W)) u_pick (
    .req (bus.rd_req),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (any_rd)
  );

  always_comb begin
    gnt_type = GNT_IDLE;
    if (bus.wr_req && !(any_rd && starve_cnt_q == STARVE_MAX)) gnt_type = GNT_WR;
    else if (any_rd)                                           gnt_type = GNT_RD;
  end

  assign bus.wr_ack       = (gnt_type == GNT_WR);
  assign bus.rd_gnt       = (gnt_type == GNT_RD) ? pick_gnt : '0;
  assign bus.ram_write_en = bus.wr_ack;
  assign bus.ram_read_en  = |bus.rd_gnt;
  assign bus.ram_addr_w   = bus.wr_addr;
  assign bus.ram_data_in  = bus.wr_data;
  assign bus.rd_data      = bus.ram_data_out;
  assign bus.rd_vld       = rd_vld_q;
  assign bus.rd_id        = rd_id_q;

  // rd_gnt is all-zero unless a read wins, so the address mux falls to 0.
  always_comb begin
    bus.ram_addr_r = '0;
    for (int i = 0; i < NUM_RD; i++)
      if (bus.rd_gnt[i]) bus.ram_addr_r = rd_addr_a[i];
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    rd_vld_d     = (gnt_type == GNT_RD);
    rd_id_d      = rd_id_q;
    if (!any_rd || gnt_type == GNT_RD) starve_cnt_d = '0;
    else if (gnt_type == GNT_WR && starve_cnt_q != STARVE_MAX)
      starve_cnt_d = starve_cnt_q + 4'd1;
    if (gnt_type == GNT_RD) begin
      rd_id_d  = pick_idx;
      rr_ptr_d = (int'(pick_idx) + 1 == NUM_RD) ? '0 : pick_idx + RD_ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      rr_ptr_q     <= '0;
      rd_vld_q     <= 1'b0;
      rd_id_q      <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      rd_vld_q     <= rd_vld_d;
      rd_id_q      <= rd_id_d;
    end
  end

`ifdef FRMPOOL_ARB_STAT_EN
  logic [15:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (stat_clr) stat_d = '0;
    else if (bus.wr_req && any_rd && stat_q != 16'hFFFF) stat_d = stat_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat_q <= '0;
    else        stat_q <= stat_d;
  end

  assign stat_conflict_cnt = stat_q;
`endif
endmodule
